// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_pkg
// Brief    : Shared encodings for the multi-cycle RV32I control path: FSM
//            states, opcodes, instruction classes and datapath select codes.
// Revision : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    CLS_LUI     = 4'd0,
    CLS_AUIPC   = 4'd1,
    CLS_JAL     = 4'd2,
    CLS_JALR    = 4'd3,
    CLS_BRANCH  = 4'd4,
    CLS_LOAD    = 4'd5,
    CLS_STORE   = 4'd6,
    CLS_OPIMM   = 4'd7,
    CLS_OP      = 4'd8,
    CLS_FENCE   = 4'd9,
    CLS_ILLEGAL = 4'd10
  } cls_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  // Immediate generator select codes; must stay aligned with the imm-gen.
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] PC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_IMM   = 2'b01;
  localparam logic [1:0] PC_ALU   = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam logic [1:0] SRC_A_RS1  = 2'b00;
  localparam logic [1:0] SRC_A_PC   = 2'b01;
  localparam logic [1:0] SRC_A_ZERO = 2'b10;

  localparam logic SRC_B_RS2 = 1'b0;
  localparam logic SRC_B_IMM = 1'b1;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_CMP   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  function automatic cls_t opcode_class(input logic [6:0] opcode);
    cls_t cls;
    case (opcode)
      OPC_LUI:    cls = CLS_LUI;
      OPC_AUIPC:  cls = CLS_AUIPC;
      OPC_JAL:    cls = CLS_JAL;
      OPC_JALR:   cls = CLS_JALR;
      OPC_BRANCH: cls = CLS_BRANCH;
      OPC_LOAD:   cls = CLS_LOAD;
      OPC_STORE:  cls = CLS_STORE;
      OPC_OPIMM:  cls = CLS_OPIMM;
      OPC_OP:     cls = CLS_OP;
      OPC_FENCE:  cls = CLS_FENCE;
      default:    cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ctrl_opdecode.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_opdecode
// Brief    : Combinational opcode decoder: instruction class, immediate select
//            and the per-instruction static datapath mux selects.
// Revision : 1.0 - initial release
// ============================================================================
module ctrl_opdecode
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output cls_t       cls,
  output logic [2:0] imm_sel,
  output logic [1:0] alu_src_a,
  output logic       alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] wb_sel,
  output logic       rd_we
);

  always_comb begin
    cls       = opcode_class(opcode);
    imm_sel   = IMM_I;
    alu_src_a = SRC_A_RS1;
    alu_src_b = SRC_B_IMM;
    alu_op    = ALU_ADD;
    wb_sel    = WB_ALU;
    rd_we     = 1'b1;

    case (cls)
      CLS_LUI: begin
        imm_sel   = IMM_U;
        alu_src_a = SRC_A_ZERO;
      end
      CLS_AUIPC: begin
        imm_sel   = IMM_U;
        alu_src_a = SRC_A_PC;
      end
      CLS_JAL: begin
        imm_sel   = IMM_J;
        alu_src_a = SRC_A_PC;
        wb_sel    = WB_PC4;
      end
      CLS_JALR: begin
        imm_sel = IMM_I;
        wb_sel  = WB_PC4;
      end
      CLS_BRANCH: begin
        imm_sel   = IMM_B;
        alu_src_b = SRC_B_RS2;
        alu_op    = ALU_CMP;
        rd_we     = 1'b0;
      end
      CLS_LOAD: begin
        imm_sel = IMM_I;
        wb_sel  = WB_MEM;
      end
      CLS_STORE: begin
        imm_sel = IMM_S;
        rd_we   = 1'b0;
      end
      CLS_OPIMM: begin
        imm_sel = IMM_I;
        alu_op  = ALU_FUNCT;
      end
      CLS_OP: begin
        alu_src_b = SRC_B_RS2;
        alu_op    = ALU_FUNCT;
      end
      // FENCE and illegal opcodes retire as NOPs with no register write.
      default: begin
        rd_we = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl
// Brief    : Multi-cycle RV32I control FSM (FETCH/DECODE/EXEC/MEM/WB) with a
//            retired-instruction counter. Define ILLEGAL_TRAP_EN to route
//            illegal opcodes into a sticky TRAP state.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          inst,
  input  logic                 mem_ready,
  input  logic                 branch_taken,
  output logic                 imem_req,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic                 ir_we,
  output logic                 pc_we,
  output logic [1:0]           pc_sel,
  output logic [2:0]           imm_sel,
  output logic [1:0]           alu_src_a,
  output logic                 alu_src_b,
  output logic [1:0]           alu_op,
  output logic                 reg_we,
  output logic [1:0]           wb_sel,
  output logic [INSTRET_W-1:0] instret,
  output logic                 trap
);

  state_t               state_q, state_d;
  logic [INSTRET_W-1:0] instret_q, instret_d;

  cls_t       dec_cls;
  logic [2:0] dec_imm_sel;
  logic [1:0] dec_alu_src_a;
  logic       dec_alu_src_b;
  logic [1:0] dec_alu_op;
  logic [1:0] dec_wb_sel;
  logic       dec_rd_we;
  logic       unused_inst_bits;

  assign unused_inst_bits = ^inst[31:7];

  ctrl_opdecode u_opdecode (
    .opcode    (inst[6:0]),
    .cls       (dec_cls),
    .imm_sel   (dec_imm_sel),
    .alu_src_a (dec_alu_src_a),
    .alu_src_b (dec_alu_src_b),
    .alu_op    (dec_alu_op),
    .wb_sel    (dec_wb_sel),
    .rd_we     (dec_rd_we)
  );

  // Outputs are pure decode of state, opcode and the two handshake inputs;
  // holding rst forces every strobe low regardless of the current state.
  always_comb begin
    state_d   = state_q;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = PC_PLUS4;
    imm_sel   = IMM_I;
    alu_src_a = SRC_A_RS1;
    alu_src_b = SRC_B_RS2;
    alu_op    = ALU_ADD;
    reg_we    = 1'b0;
    wb_sel    = WB_ALU;
    trap      = 1'b0;

    if (!rst) begin
      // The IR only holds the current instruction from DECODE onwards.
      if (state_q == ST_DECODE || state_q == ST_EXEC ||
          state_q == ST_MEM    || state_q == ST_WB) begin
        imm_sel   = dec_imm_sel;
        alu_src_a = dec_alu_src_a;
        alu_src_b = dec_alu_src_b;
        alu_op    = dec_alu_op;
        wb_sel    = dec_wb_sel;
      end

      case (state_q)
        ST_FETCH: begin
          imem_req = 1'b1;
          if (mem_ready) begin
            ir_we   = 1'b1;
            state_d = ST_DECODE;
          end
        end
        ST_DECODE: begin
          state_d = ST_EXEC;
`ifdef ILLEGAL_TRAP_EN
          if (dec_cls == CLS_ILLEGAL) begin
            state_d = ST_TRAP;
          end
`endif
        end
        ST_EXEC: begin
          case (dec_cls)
            CLS_BRANCH: begin
              pc_we   = 1'b1;
              pc_sel  = branch_taken ? PC_IMM : PC_PLUS4;
              state_d = ST_FETCH;
            end
            CLS_LOAD, CLS_STORE: state_d = ST_MEM;
            default:             state_d = ST_WB;
          endcase
        end
        ST_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = (dec_cls == CLS_STORE);
          if (mem_ready) begin
            if (dec_cls == CLS_STORE) begin
              pc_we   = 1'b1;
              pc_sel  = PC_PLUS4;
              state_d = ST_FETCH;
            end else begin
              state_d = ST_WB;
            end
          end
        end
        ST_WB: begin
          reg_we  = dec_rd_we;
          pc_we   = 1'b1;
          state_d = ST_FETCH;
          case (dec_cls)
            CLS_JAL:  pc_sel = PC_IMM;
            CLS_JALR: pc_sel = PC_ALU;
            default:  pc_sel = PC_PLUS4;
          endcase
        end
        ST_TRAP: begin
`ifdef ILLEGAL_TRAP_EN
          trap = 1'b1;
`else
          state_d = ST_FETCH;
`endif
        end
        default: state_d = ST_FETCH;
      endcase
    end
  end

  assign instret_d = instret_q + INSTRET_W'(pc_we);
  assign instret   = rst ? '0 : instret_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_FETCH;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_ctrl
// Brief    : Directed self-checking bench for multicycle_ctrl; expected output
//            bundles are hand-derived per cycle for each instruction.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst;
  logic        mem_ready;
  logic        branch_taken;
  logic        imem_req, dmem_req, dmem_we, ir_we, pc_we;
  logic [1:0]  pc_sel;
  logic [2:0]  imm_sel;
  logic [1:0]  alu_src_a;
  logic        alu_src_b;
  logic [1:0]  alu_op;
  logic        reg_we;
  logic [1:0]  wb_sel;
  logic [31:0] instret;
  logic        trap;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.INSTRET_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .inst         (inst),
    .mem_ready    (mem_ready),
    .branch_taken (branch_taken),
    .imem_req     (imem_req),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .ir_we        (ir_we),
    .pc_we        (pc_we),
    .pc_sel       (pc_sel),
    .imm_sel      (imm_sel),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .alu_op       (alu_op),
    .reg_we       (reg_we),
    .wb_sel       (wb_sel),
    .instret      (instret),
    .trap         (trap)
  );

  logic [18:0] obs;
  assign obs = {imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, imm_sel,
                alu_src_a, alu_src_b, alu_op, reg_we, wb_sel, trap};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Packs one cycle's expected output bundle in the same order as obs.
  function automatic logic [18:0] o(input logic im, input logic dr, input logic dw,
                                    input logic ir, input logic pw, input logic [1:0] ps,
                                    input logic [2:0] is, input logic [1:0] sa,
                                    input logic sb, input logic [1:0] ao, input logic rw,
                                    input logic [1:0] wb, input logic tp);
    return {im, dr, dw, ir, pw, ps, is, sa, sb, ao, rw, wb, tp};
  endfunction

  // Entered just after a rising edge: drive, settle, check, advance one cycle.
  task automatic cyc(input logic r, input logic mr, input logic bt,
                     input logic [18:0] exp, input string tag);
    rst          = r;
    mem_ready    = mr;
    branch_taken = bt;
    #2;
    chk(tag, {13'd0, obs}, {13'd0, exp});
    @(posedge clk);
    #1;
  endtask

  logic [18:0] fetch_ok, idle;

  initial begin
    fetch_ok     = o(1,0,0,1,0,2'b00,3'b000,2'b00,0,2'b00,0,2'b00,0);
    idle         = '0;
    rst          = 1'b1;
    mem_ready    = 1'b0;
    branch_taken = 1'b0;
    inst         = 32'h0;
    @(posedge clk);
    #1;

    // Reset with handshake inputs high: everything must stay quiet.
    cyc(1, 1, 1, idle, "rst_outputs");
    chk("rst_instret", instret, 32'd0);

    // ADDI x1, x0, 5
    inst = 32'h00500093;
    cyc(0, 1, 0, fetch_ok, "addi_fetch");
    cyc(0, 0, 0, o(0,0,0,0,0,2'b00,3'b000,2'b00,1,2'b10,0,2'b00,0), "addi_decode");
    cyc(0, 1, 0, o(0,0,0,0,0,2'b00,3'b000,2'b00,1,2'b10,0,2'b00,0), "addi_exec");
    cyc(0, 0, 0, o(0,0,0,0,1,2'b00,3'b000,2'b00,1,2'b10,1,2'b00,0), "addi_wb");
    chk("addi_instret", instret, 32'd1);

    // BEQ taken: retires out of EXEC
    inst = 32'h00208463;
    cyc(0, 1, 1, fetch_ok, "beq_fetch");
    cyc(0, 1, 1, o(0,0,0,0,0,2'b00,3'b010,2'b00,0,2'b01,0,2'b00,0), "beq_decode");
    cyc(0, 1, 1, o(0,0,0,0,1,2'b01,3'b010,2'b00,0,2'b01,0,2'b00,0), "beq_exec");
    chk("beq_instret", instret, 32'd2);
    cyc(0, 0, 0, o(1,0,0,0,0,2'b00,3'b000,2'b00,0,2'b00,0,2'b00,0), "beq_next_fetch");

    // LW with two memory wait cycles: 7 cycles total
    inst = 32'h0000a103;
    cyc(0, 1, 0, fetch_ok, "lw_fetch");
    cyc(0, 1, 0, o(0,0,0,0,0,2'b00,3'b000,2'b00,1,2'b00,0,2'b01,0), "lw_decode");
    cyc(0, 1, 0, o(0,0,0,0,0,2'b00,3'b000,2'b00,1,2'b00,0,2'b01,0), "lw_exec");
    cyc(0, 0, 0, o(0,1,0,0,0,2'b00,3'b000,2'b00,1,2'b00,0,2'b01,0), "lw_mem_wait1");
    cyc(0, 0, 0, o(0,1,0,0,0,2'b00,3'b000,2'b00,1,2'b00,0,2'b01,0), "lw_mem_wait2");
    cyc(0, 1, 0, o(0,1,0,0,0,2'b00,3'b000,2'b00,1,2'b00,0,2'b01,0), "lw_mem_done");
    cyc(0, 0, 0, o(0,0,0,0,1,2'b00,3'b000,2'b00,1,2'b00,1,2'b01,0), "lw_wb");
    chk("lw_instret", instret, 32'd3);

    cyc(1, 0, 0, idle, "rst2_outputs");
    chk("rst2_instret", instret, 32'd0);

    // JALR then LUI
    inst = 32'h000080e7;
    cyc(0, 1, 0, fetch_ok, "jalr_fetch");
    cyc(0, 1, 0, o(0,0,0,0,0,2'b00,3'b000,2'b00,1,2'b00,0,2'b10,0), "jalr_decode");
    cyc(0, 1, 0, o(0,0,0,0,0,2'b00,3'b000,2'b00,1,2'b00,0,2'b10,0), "jalr_exec");
    cyc(0, 1, 0, o(0,0,0,0,1,2'b10,3'b000,2'b00,1,2'b00,1,2'b10,0), "jalr_wb");
    inst = 32'h123450b7;
    cyc(0, 1, 0, fetch_ok, "lui_fetch");
    cyc(0, 1, 0, o(0,0,0,0,0,2'b00,3'b100,2'b10,1,2'b00,0,2'b00,0), "lui_decode");
    cyc(0, 1, 0, o(0,0,0,0,0,2'b00,3'b100,2'b10,1,2'b00,0,2'b00,0), "lui_exec");
    cyc(0, 1, 0, o(0,0,0,0,1,2'b00,3'b100,2'b10,1,2'b00,1,2'b00,0), "lui_wb");
    chk("jalr_lui_instret", instret, 32'd2);

    // SW aborted by reset during its memory wait
    inst = 32'h0020a023;
    cyc(0, 1, 0, fetch_ok, "sw_fetch");
    cyc(0, 1, 0, o(0,0,0,0,0,2'b00,3'b001,2'b00,1,2'b00,0,2'b00,0), "sw_decode");
    cyc(0, 1, 0, o(0,0,0,0,0,2'b00,3'b001,2'b00,1,2'b00,0,2'b00,0), "sw_exec");
    cyc(0, 0, 0, o(0,1,1,0,0,2'b00,3'b001,2'b00,1,2'b00,0,2'b00,0), "sw_mem_wait");
    cyc(1, 1, 0, idle, "sw_rst_cycle");
    cyc(0, 0, 0, o(1,0,0,0,0,2'b00,3'b000,2'b00,0,2'b00,0,2'b00,0), "post_rst_fetch_hold");
    chk("sw_abort_instret", instret, 32'd0);

    // Opcode 0000000
    inst = 32'h00000000;
    cyc(0, 1, 0, fetch_ok, "ill_fetch");
    cyc(0, 1, 0, o(0,0,0,0,0,2'b00,3'b000,2'b00,1,2'b00,0,2'b00,0), "ill_decode");
`ifdef ILLEGAL_TRAP_EN
    cyc(0, 1, 1, o(0,0,0,0,0,2'b00,3'b000,2'b00,0,2'b00,0,2'b00,1), "ill_trap1");
    cyc(0, 1, 1, o(0,0,0,0,0,2'b00,3'b000,2'b00,0,2'b00,0,2'b00,1), "ill_trap2");
    chk("ill_instret", instret, 32'd0);
    cyc(1, 0, 0, idle, "ill_rst");
    cyc(0, 0, 0, o(1,0,0,0,0,2'b00,3'b000,2'b00,0,2'b00,0,2'b00,0), "ill_refetch");
`else
    cyc(0, 1, 0, o(0,0,0,0,0,2'b00,3'b000,2'b00,1,2'b00,0,2'b00,0), "ill_exec");
    cyc(0, 1, 0, o(0,0,0,0,1,2'b00,3'b000,2'b00,1,2'b00,0,2'b00,0), "ill_wb");
    chk("ill_instret", instret, 32'd1);
    cyc(0, 0, 0, o(1,0,0,0,0,2'b00,3'b000,2'b00,0,2'b00,0,2'b00,0), "ill_next_fetch");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
